// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first unsigned subtractor computing (a - b) mod 2^WIDTH.
//   Each RUN cycle handles one bit with a difference/borrow cell and a
//   registered borrow, so one result takes WIDTH cycles in RUN.
//   A start/busy/done handshake controls it. The result is held until the
//   next operation completes or a reset occurs.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous active-high reset
//   start      : request pulse; accepted only in IDLE or DONE
//   a, b       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while the operation is in progress (RUN)
//   done       : one-cycle pulse; diff/borrow_out are valid from this cycle
//   diff       : (a - b) mod 2^WIDTH
//   borrow_out : 1 when a < b (unsigned)
module serial_subtractor #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic             br_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] part_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_reg;

  logic             bit_x;
  logic             bit_y;
  logic             d_next;
  logic             br_next;
  logic [WIDTH-1:0] part_next;
  logic             last_bit;

  // Difference/borrow cell for the current LSB of the shifting operands.
  always_comb begin
    bit_x     = sa_reg[0];
    bit_y     = sb_reg[0];
    d_next    = bit_x ^ bit_y ^ br_reg;
    br_next   = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & br_reg);
    // Difference bits enter at the MSB; after WIDTH shifts bit 0 sits at LSB.
    part_next = {d_next, part_reg[WIDTH-1:1]};
    last_bit  = (cnt_reg == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      br_reg     <= 1'b0;
      cnt_reg    <= '0;
      part_reg   <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_reg <= ST_RUN;
            sa_reg    <= a;
            sb_reg    <= b;
            br_reg    <= 1'b0;
            cnt_reg   <= '0;
            part_reg  <= '0;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sa_reg   <= sa_reg >> 1;
          sb_reg   <= sb_reg >> 1;
          br_reg   <= br_next;
          part_reg <= part_next;
          cnt_reg  <= cnt_reg + CNT_W'(1);
          // The published result only moves on the edge that finishes the
          // last bit, so it stays stable through a following RUN.
          if (last_bit) begin
            state_reg  <= ST_DONE;
            diff_reg   <= part_next;
            borrow_reg <= br_next;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (state_reg == ST_RUN);
  assign done       = (state_reg == ST_DONE);
  assign diff       = diff_reg;
  assign borrow_out = borrow_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and random stimulus for serial_subtractor (WIDTH=8) with a
//   cycle-level behavioural model checked on every falling edge, plus
//   literal expectations for the hand-computed cases.
module tb_serial_subtractor;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int checks = 0;
  int errors = 0;
  int prints = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: an operation occupies WIDTH cycles, then the
  // arithmetic result appears together with a one-cycle done.
  logic             m_busy, m_done, m_bo, m_en = 1'b0;
  logic [WIDTH-1:0] m_diff;
  logic [WIDTH:0]   m_pend;
  int               m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_diff = '0; m_bo = 1'b0; m_en = 1'b1;
    end else if (m_busy) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_diff = m_pend[WIDTH-1:0]; m_bo = m_pend[WIDTH];
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1; m_left = WIDTH;
        m_pend = {1'b0, a} - {1'b0, b};
      end
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      if (prints < 40) begin
        prints++;
        $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
      end
    end
  endtask

  // Single compare process against the model.
  always @(negedge clk) begin
    if (m_en) begin
      check("model_busy", int'(busy), int'(m_busy));
      check("model_done", int'(done), int'(m_done));
      check("model_diff", int'(diff), int'(m_diff));
      check("model_borrow", int'(borrow_out), int'(m_bo));
    end
  end

  // Drive start for one accepting edge; returns at accept edge + 1.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = ~av; b = ~bv;
  endtask

  // Counts falling edges until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic op(input string name, input logic [WIDTH-1:0] av,
                    input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] ed,
                    input logic eb);
    int n;
    launch(av, bv);
    wait_done(n);
    check({name, "_latency"}, n, WIDTH + 1);
    check({name, "_diff"}, int'(diff), int'(ed));
    check({name, "_borrow"}, int'(borrow_out), int'(eb));
    $display("op %s a=%0h b=%0h diff=%0h borrow=%0b cycles=%0d", name, av, bv, diff, borrow_out, n);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH:0]   ref_v;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_diff", int'(diff), 0);
    check("reset_borrow", int'(borrow_out), 0);

    op("basic", 8'd5, 8'd3, 8'h02, 1'b0);
    op("neg", 8'd3, 8'd5, 8'hFE, 1'b1);
    op("ripple", 8'h00, 8'h01, 8'hFF, 1'b1);
    op("max", 8'hFF, 8'h00, 8'hFF, 1'b0);
    op("equal", 8'hA5, 8'hA5, 8'h00, 1'b0);

    // Start during RUN must be ignored.
    launch(8'd10, 8'd4);
    @(posedge clk); #1;
    start = 1'b1; a = 8'd1; b = 8'd2;
    @(posedge clk); #1;
    start = 1'b0; a = 8'd77; b = 8'd99;
    wait_done(n);
    check("ignore_diff", int'(diff), 8'h06);
    check("ignore_borrow", int'(borrow_out), 0);
    $display("op ignore_restart diff=%0h borrow=%0b", diff, borrow_out);

    // Back-to-back: start held high through done.
    launch(8'd20, 8'd5);
    start = 1'b1; a = 8'd7; b = 8'd9;
    wait_done(n);
    check("b2b_first_diff", int'(diff), 8'h0F);
    check("b2b_first_borrow", int'(borrow_out), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_no_idle_busy", int'(busy), 1);
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    check("b2b_latency", n, WIDTH + 1);
    check("b2b_second_diff", int'(diff), 8'hFE);
    check("b2b_second_borrow", int'(borrow_out), 1);
    $display("op back_to_back diff=%0h borrow=%0b cycles=%0d", diff, borrow_out, n);

    // Reset in the middle of RUN.
    launch(8'd50, 8'd8);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_diff", int'(diff), 0);
    check("midrst_borrow", int'(borrow_out), 0);
    n = 0;
    repeat (12) begin @(negedge clk); if (done) n++; end
    check("midrst_no_done", n, 0);
    $display("op mid_run_reset diff=%0h borrow=%0b", diff, borrow_out);
    op("after_rst", 8'd50, 8'd8, 8'd42, 1'b0);

    for (int i = 0; i < 500; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      ref_v = {1'b0, ra} - {1'b0, rb};
      launch(ra, rb);
      wait_done(n);
      check("rand_diff", int'(diff), int'(ref_v[WIDTH-1:0]));
      check("rand_borrow", int'(borrow_out), int'(ref_v[WIDTH]));
      if (i % 50 == 0)
        $display("op rand%0d a=%0h b=%0h diff=%0h borrow=%0b", i, ra, rb, diff, borrow_out);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
